// File: rtl/raster_engine.sv
// Frame-buffer rasterizer: CLEAR / PIXEL / LINE / RECT at one pixel write per cycle,
// and FLUSH streams the frame row-major over a valid/ready pixel port.
module raster_engine #(
    parameter int W_BITS   = 3,
    parameter int H_BITS   = 3,
    parameter int PIX_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [W_BITS-1:0]   cmd_x0,
    input  logic [W_BITS-1:0]   cmd_x1,
    input  logic [H_BITS-1:0]   cmd_y0,
    input  logic [H_BITS-1:0]   cmd_y1,
    input  logic [PIX_BITS-1:0] cmd_color,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [PIX_BITS-1:0] pix_data,
    output logic                pix_last
);
    localparam int A_BITS = W_BITS + H_BITS;
    localparam int N_PIX  = 1 << A_BITS;
    localparam int E_BITS = ((W_BITS > H_BITS) ? W_BITS : H_BITS) + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_NOP, S_CLEAR, S_PIXEL, S_LINE, S_RECT, S_STREAM
    } state_t;

    state_t                    state_q, state_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic [W_BITS-1:0]         x_q, x_d, xmin_q, xmin_d, xend_q, xend_d;
    logic [H_BITS-1:0]         y_q, y_d, yend_q, yend_d;
    logic [PIX_BITS-1:0]       color_q, color_d;
    logic                      sx_q, sx_d, sy_q, sy_d;
    logic signed [E_BITS-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                      pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
    logic [PIX_BITS-1:0]       pix_data_q, pix_data_d;
    logic [PIX_BITS-1:0]       fb_q [N_PIX];

    logic                      we_s;
    logic [A_BITS-1:0]         addr_next_s;
    logic [W_BITS-1:0]         adx_s;
    logic [H_BITS-1:0]         ady_s;
    logic signed [E_BITS-1:0]  ldx_s, ldy_s, e2_s, err_n_s;

    assign cmd_ready = cmd_ready_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_last  = pix_last_q;

    // Next-state, write-port and stream-register computation.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xmin_d      = xmin_q;
        xend_d      = xend_q;
        yend_d      = yend_q;
        color_d     = color_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_last_d  = pix_last_q;
        we_s        = 1'b0;
        err_n_s     = err_q;
        addr_next_s = {y_q, x_q} + A_BITS'(1);
        e2_s        = err_q <<< 1;
        adx_s       = (cmd_x1 >= cmd_x0) ? (cmd_x1 - cmd_x0) : (cmd_x0 - cmd_x1);
        ady_s       = (cmd_y1 >= cmd_y0) ? (cmd_y1 - cmd_y0) : (cmd_y0 - cmd_y1);
        ldx_s       = $signed({{(E_BITS-W_BITS){1'b0}}, adx_s});
        ldy_s       = -$signed({{(E_BITS-H_BITS){1'b0}}, ady_s});

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    color_d = cmd_color;
                    x_d     = cmd_x0;
                    y_d     = cmd_y0;
                    xend_d  = cmd_x1;
                    yend_d  = cmd_y1;
                    case (cmd_op)
                        3'b001: begin
                            state_d = S_CLEAR;
                            x_d     = '0;
                            y_d     = '0;
                        end
                        3'b010: state_d = S_PIXEL;
                        3'b011: begin
                            state_d = S_LINE;
                            dx_d    = ldx_s;
                            dy_d    = ldy_s;
                            err_d   = ldx_s + ldy_s;
                            sx_d    = (cmd_x1 < cmd_x0);
                            sy_d    = (cmd_y1 < cmd_y0);
                        end
                        3'b100: begin
                            state_d = S_RECT;
                            x_d     = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
                            xmin_d  = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
                            xend_d  = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
                            y_d     = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
                            yend_d  = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
                        end
                        3'b101: begin
                            state_d     = S_STREAM;
                            x_d         = '0;
                            y_d         = '0;
                            pix_valid_d = 1'b1;
                            pix_data_d  = fb_q[0];
                            pix_last_d  = 1'b0;
                        end
                        default: state_d = S_NOP;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NOP: state_d = S_IDLE;
            S_PIXEL: begin
                we_s    = 1'b1;
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                we_s = 1'b1;
                if ((x_q == {W_BITS{1'b1}}) && (y_q == {H_BITS{1'b1}})) begin
                    state_d = S_IDLE;
                end else begin
                    {y_d, x_d} = addr_next_s;
                end
            end
            S_RECT: begin
                we_s = 1'b1;
                if (x_q == xend_q) begin
                    if (y_q == yend_q) begin
                        state_d = S_IDLE;
                    end else begin
                        x_d = xmin_q;
                        y_d = y_q + H_BITS'(1);
                    end
                end else begin
                    x_d = x_q + W_BITS'(1);
                end
            end
            S_LINE: begin
                we_s = 1'b1;
                if ((x_q == xend_q) && (y_q == yend_q)) begin
                    state_d = S_IDLE;
                end else begin
                    // Both Bresenham tests use the pre-update e2.
                    if (e2_s >= dy_q) begin
                        err_n_s = err_n_s + dy_q;
                        x_d     = sx_q ? (x_q - W_BITS'(1)) : (x_q + W_BITS'(1));
                    end else begin
                        x_d = x_q;
                    end
                    if (e2_s <= dx_q) begin
                        err_n_s = err_n_s + dx_q;
                        y_d     = sy_q ? (y_q - H_BITS'(1)) : (y_q + H_BITS'(1));
                    end else begin
                        y_d = y_q;
                    end
                    err_d = err_n_s;
                end
            end
            S_STREAM: begin
                if (pix_ready) begin
                    if (pix_last_q) begin
                        pix_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        {y_d, x_d} = addr_next_s;
                        pix_data_d = fb_q[addr_next_s];
                        pix_last_d = (addr_next_s == {A_BITS{1'b1}});
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
    end

    // Control and stream registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            xmin_q      <= '0;
            xend_q      <= '0;
            yend_q      <= '0;
            color_q     <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xmin_q      <= xmin_d;
            xend_q      <= xend_d;
            yend_q      <= yend_d;
            color_q     <= color_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_last_q  <= pix_last_d;
        end
    end

    // Single-write-port frame buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PIX; i++) begin
                fb_q[i] <= '0;
            end
        end else if (we_s) begin
            fb_q[{y_q, x_q}] <= color_q;
        end else begin
            fb_q[{y_q, x_q}] <= fb_q[{y_q, x_q}];
        end
    end
endmodule

// File: tb/tb_raster_engine.sv
// Directed bench for raster_engine: commands update a hand-built reference frame;
// FLUSH pushes expected beats into a queue that a negedge monitor pops and compares.
module tb_raster_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [2:0] cmd_x0 = 3'd0, cmd_x1 = 3'd0, cmd_y0 = 3'd0, cmd_y1 = 3'd0;
    logic [3:0] cmd_color = 4'h0;
    logic       pix_valid;
    logic       pix_ready = 1'b1;
    logic [3:0] pix_data;
    logic       pix_last;

    int checks = 0;
    int errors = 0;
    logic [3:0] model [64];
    logic [4:0] exp_q [$];
    int  beat_cnt = 0;
    bit  tog_en = 1'b0;
    int  tog_i = 0;
    bit  prev_stall = 1'b0;
    logic [3:0] prev_data;
    logic       prev_last;

    raster_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0),
        .cmd_y1(cmd_y1), .cmd_color(cmd_color), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats on each handshake and checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && pix_valid) begin
                if (prev_stall) begin
                    chk("stall_data", pix_data, prev_data);
                    chk("stall_last", pix_last, prev_last);
                end
                prev_stall = !pix_ready;
                prev_data  = pix_data;
                prev_last  = pix_last;
                if (pix_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        logic [4:0] e;
                        e = exp_q.pop_front();
                        chk($sformatf("beat%0d_data", beat_cnt), pix_data, e[3:0]);
                        chk($sformatf("beat%0d_last", beat_cnt), pix_last, e[4]);
                    end
                    beat_cnt++;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Ready pattern 1,0,0 repeating when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                pix_ready = ((tog_i % 3) == 0);
                tog_i++;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input int x0, input int y0,
                         input int x1, input int y1, input logic [3:0] col);
        int n;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        if (op == 3'b101) begin
            for (int i = 0; i < 64; i++) exp_q.push_back({(i == 63), model[i]});
            beat_cnt = 0;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_color = col;
        cmd_x0 = 3'(x0); cmd_y0 = 3'(y0); cmd_x1 = 3'(x1); cmd_y1 = 3'(y1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 3'b000;
    endtask

    task automatic cmd(string name, input logic [2:0] op, input int x0, input int y0,
                       input int x1, input int y1, input logic [3:0] col, input int exp_busy);
        int busy;
        issue(op, x0, y0, x1, y1, col);
        busy = 0;
        while (!cmd_ready && busy < 5000) begin
            busy++;
            @(posedge clk); #1;
        end
        if (exp_busy >= 0) chk({name, "_busy"}, busy, exp_busy);
        else chk({name, "_done"}, cmd_ready, 1);
        if (op == 3'b101) chk({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic model_fill(input logic [3:0] c);
        for (int i = 0; i < 64; i++) model[i] = c;
    endtask

    initial begin
        model_fill(4'h0);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_pix_last", pix_last, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_cmd_ready_low", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rel_cmd_ready_high", cmd_ready, 1);

        cmd("flush_zero", 3'b101, 0, 0, 0, 0, 4'h0, 64);

        cmd("clear_a", 3'b001, 0, 0, 0, 0, 4'hA, 64);
        model_fill(4'hA);
        cmd("flush_a", 3'b101, 0, 0, 0, 0, 4'h0, 64);

        // Line (6,1)->(1,4): hand-traced Bresenham pixels.
        cmd("clear_0", 3'b001, 0, 0, 0, 0, 4'h0, 64);
        model_fill(4'h0);
        cmd("line", 3'b011, 6, 1, 1, 4, 4'h5, 6);
        model[1*8+6] = 4'h5; model[2*8+5] = 4'h5; model[2*8+4] = 4'h5;
        model[3*8+3] = 4'h5; model[3*8+2] = 4'h5; model[4*8+1] = 4'h5;
        cmd("flush_line", 3'b101, 0, 0, 0, 0, 4'h0, 64);

        // Swapped-corner rect covers x2..5, y4..6.
        cmd("clear_0b", 3'b001, 0, 0, 0, 0, 4'h0, 64);
        model_fill(4'h0);
        cmd("rect", 3'b100, 5, 6, 2, 4, 4'h3, 12);
        for (int y = 4; y <= 6; y++)
            for (int x = 2; x <= 5; x++) model[y*8+x] = 4'h3;
        cmd("flush_rect", 3'b101, 0, 0, 0, 0, 4'h0, 64);

        cmd("pixel", 3'b010, 7, 0, 0, 0, 4'h9, 1);
        model[7] = 4'h9;
        cmd("degen_line", 3'b011, 0, 7, 0, 7, 4'hC, 1);
        model[56] = 4'hC;
        cmd("nop", 3'b000, 3, 3, 3, 3, 4'hF, 1);
        cmd("op111", 3'b111, 3, 3, 3, 3, 4'hF, 1);

        tog_i = 0; tog_en = 1'b1;
        cmd("flush_stall", 3'b101, 0, 0, 0, 0, 4'h0, -1);
        tog_en = 1'b0;
        @(posedge clk); #1;
        pix_ready = 1'b1;

        // Reset while beat 20 is presented.
        issue(3'b101, 0, 0, 0, 0, 4'h0);
        begin
            int n;
            n = 0;
            while (beat_cnt < 20 && n < 500) begin
                @(posedge clk); #1; n++;
            end
            chk("reach_beat20", beat_cnt, 20);
        end
        rst = 1'b1;
        #1;
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        model_fill(4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready_after", cmd_ready, 1);
        chk("midrst_no_beat", pix_valid, 0);
        cmd("flush_after_rst", 3'b101, 0, 0, 0, 0, 4'h0, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/raster_engine.md
Name: raster_engine

Overview:
- Parametrised successor of the 8x8 single-bit rasterizer.
- Holds a 2^W_BITS x 2^H_BITS frame buffer with PIX_BITS of colour per pixel.
- Executes CLEAR, PIXEL, LINE (full-octant Bresenham) and RECT commands at one pixel write per cycle.
- Streams the frame row-major on a valid/ready pixel port when FLUSH is issued. Sits between the command decoder and the display serializer.

Parameters:
- W_BITS, 3, x coordinate width; frame width W = 2^W_BITS.
- H_BITS, 3, y coordinate width; frame height H = 2^H_BITS.
- PIX_BITS, 4, colour bits per pixel.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  000 NOP, 001 CLEAR, 010 PIXEL, 011 LINE, 100 RECT, 101 FLUSH, 110/111 treated as NOP.
- cmd_x0, cmd_x1  in  W_BITS  x coordinates.
- cmd_y0, cmd_y1  in  H_BITS  y coordinates.
- cmd_color  in  PIX_BITS  colour written by CLEAR/PIXEL/LINE/RECT.
- pix_valid  out  1  pixel beat valid.
- pix_ready  in  1  sink accepts beat.
- pix_data  out  PIX_BITS  pixel colour.
- pix_last  out  1  final pixel of frame (x=W-1, y=H-1).

Behaviour:
- Reset (async, immediate): state IDLE, frame buffer all 0, cmd_ready=0, pix_valid=0, pix_data=0, pix_last=0. cmd_ready rises at the first clk edge after rst falls. Reset mid-command or mid-stream aborts with no further writes or beats.
- States: IDLE, NOP, CLEAR, PIXEL, LINE, RECT, STREAM. cmd_ready=1 only in IDLE.
- Accept edge E0: all cmd_* fields latched; state set from cmd_op; cmd_ready=0 from E0. Inputs are ignored outside IDLE.
- Exec states perform one write per edge starting at E1. The last write's edge returns to IDLE, so cmd_ready is high in the following cycle.
- Write counts:
  - NOP: 1 cycle, no write.
  - PIXEL: 1 cycle.
  - CLEAR: W*H cycles, row-major address walk, every pixel set to cmd_color.
  - RECT: xmin=min(x0,x1), xmax=max(x0,x1), same for y. Inclusive fill, row-major from (xmin,ymin). (xmax-xmin+1)*(ymax-ymin+1) cycles.
  - LINE: Bresenham from (x0,y0) to (x1,y1) inclusive, all octants. dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy. Each cycle: write (x,y); e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Terminates after writing the endpoint: max(dx,|dy|)+1 cycles. err/e2 signed, max(W_BITS,H_BITS)+2 bits, no overflow. Degenerate line (x0,y0)==(x1,y1) writes one pixel.
- Coordinate wrap is impossible, since dimensions are powers of two and every coordinate is in range.
- FLUSH/STREAM:
  - pix_valid=1 from E1. Beats go row-major, y=0..H-1, x=0..W-1.
  - pix_data is registered and reflects the buffer at the time the beat is presented.
  - A beat advances only on pix_valid && pix_ready. pix_data and pix_last hold stable while pix_ready=0.
  - pix_last=1 only on the beat (W-1,H-1). Its handshake drops pix_valid and returns to IDLE.
  - With pix_ready tied high: exactly W*H beats in W*H consecutive cycles, and cmd_ready is low for W*H cycles.
- Frame buffer has a single write port. STREAM never writes, so reads never race writes.
- Between commands the buffer is persistent. Later writes overwrite earlier ones.

Test Plan:
- Reset, then FLUSH with pix_ready=1 -> 64 beats all pix_data=0; pix_last only on beat 63; cmd_ready high the cycle after.
- CLEAR color=4'hA, then FLUSH -> all 64 beats 4'hA; cmd_ready low exactly 64 cycles for CLEAR.
- CLEAR 0; LINE (6,1)->(1,4) color 5; FLUSH -> exactly (6,1),(5,2),(4,2),(3,3),(2,3),(1,4) are 5 and all others 0. LINE busy 6 cycles.
- CLEAR 0; RECT x0=5,y0=6,x1=2,y1=4 color 3 (swapped corners); FLUSH -> x2..5, y4..6 (12 pixels) are 3. RECT busy 12 cycles.
- FLUSH with pix_ready toggling 1,0,0,1,… -> pix_data and pix_last are stable during stalls, the beat sequence matches the buffer, and no beat is dropped or duplicated.
- Assert rst during beat 20 of a FLUSH -> pix_valid=0 immediately; after release cmd_ready=1, and a new FLUSH returns all zeros.
